radix_entry_encoder: RTL

//  Inverse of the binary-to-radix display path: the operator keys in up to two digits in
//  the selected radix (octal, decimal or hex). The block validates each digit and

---
 rtl/radix_entry_encoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/radix_entry_encoder.sv
// radix_entry_encoder
//   Front-panel digit entry. The operator keys in up to two digits in the active
//   radix (octal, decimal or hex). Each digit is checked against the radix, and the
//   digits are accumulated into a VALUE_W-bit binary value. A committed value is
//   published with a one-cycle valid strobe. An illegal digit or an overflow
//   produces a one-cycle error strobe instead.
//
//   State table
//     IDLE  | no digit held; the next legal digit starts a new entry
//     HAVE1 | one legal digit is held in acc_q
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   digit_in_i     operator digit value, 0..15
//   enter_i        button: capture digit_in_i (rising edge acts)
//   commit_i       button: finish the entry with the held digit (rising edge acts)
//   mode_switch_i  button: step the radix octal -> decimal -> hex (rising edge acts)
//   clear_i        level: abort the current entry
//   value_o        last committed binary value
//   value_valid_o  one-cycle pulse when value_o is updated
//   err_o          one-cycle pulse on an illegal digit or an overflow
//   radix_o        00 octal, 01 decimal, 10 hex
//   busy_o         high while one digit is held
module radix_entry_encoder #(
  parameter int VALUE_W = 4,
  parameter int ACC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         digit_in_i,
  input  logic               enter_i,
  input  logic               commit_i,
  input  logic               mode_switch_i,
  input  logic               clear_i,
  output logic [VALUE_W-1:0] value_o,
  output logic               value_valid_o,
  output logic               err_o,
  output logic [1:0]         radix_o,
  output logic               busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    HAVE1 = 1'b1
  } state_e;

  localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'((1 << VALUE_W) - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [1:0]         radix_q, radix_d;
  logic               enter_last_q, commit_last_q, mode_last_q;

  logic               enter_edge, commit_edge, mode_edge;
  logic [4:0]         base;
  logic               digit_legal;
  logic [ACC_W-1:0]   combined;

  assign enter_edge  = enter_i & ~enter_last_q;
  assign commit_edge = commit_i & ~commit_last_q;
  assign mode_edge   = mode_switch_i & ~mode_last_q;

  always_comb begin
    base = 5'd16;
    case (radix_q)
      2'b00:   base = 5'd8;
      2'b01:   base = 5'd10;
      default: base = 5'd16;
    endcase
  end

  assign digit_legal = ({1'b0, digit_in_i} < base);

  // Held digit is below the base (<=15) and base <= 16, so this never exceeds 255.
  assign combined = acc_q * ACC_W'(base) + ACC_W'(digit_in_i);

  // State register, including edge-detect history and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      value_q       <= '0;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
      radix_q       <= 2'b00;
      enter_last_q  <= 1'b0;
      commit_last_q <= 1'b0;
      mode_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      value_q       <= value_d;
      valid_q       <= valid_d;
      err_q         <= err_d;
      radix_q       <= radix_d;
      enter_last_q  <= enter_i;
      commit_last_q <= commit_i;
      mode_last_q   <= mode_switch_i;
    end
  end

  // Next state and accumulator. Only the highest-priority event of a cycle acts.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (clear_i || mode_edge) begin
      state_d = IDLE;
      acc_d   = '0;
    end else if (enter_edge) begin
      if (digit_legal) begin
        if (state_q == IDLE) begin
          state_d = HAVE1;
          acc_d   = ACC_W'(digit_in_i);
        end else begin
          state_d = IDLE;
          acc_d   = '0;
        end
      end
    end else if (commit_edge && state_q == HAVE1) begin
      state_d = IDLE;
      acc_d   = '0;
    end
  end

  // Output next values.
  always_comb begin
    value_d = value_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    radix_d = radix_q;
    if (clear_i) begin
      // abort only; nothing published
    end else if (mode_edge) begin
      radix_d = (radix_q == 2'b10) ? 2'b00 : radix_q + 2'b01;
    end else if (enter_edge) begin
      if (!digit_legal) begin
        err_d = 1'b1;
      end else if (state_q == HAVE1) begin
        if (combined <= MAX_VAL) begin
          value_d = combined[VALUE_W-1:0];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (commit_edge && state_q == HAVE1) begin
      value_d = acc_q[VALUE_W-1:0];
      valid_d = 1'b1;
    end
  end

  assign value_o       = value_q;
  assign value_valid_o = valid_q;
  assign err_o         = err_q;
  assign radix_o       = radix_q;
  assign busy_o        = (state_q == HAVE1);

endmodule
